pipe_delay_line: RTL
====================

// Module: pipe_delay_line
// PURPOSE
//  Parametrised multi-stage delay line for pipeline control/data fields: WIDTH-bit
//  payload plus valid bit shifted through DEPTH register stages. Adds global stall,
//  per-stage selective flush (kill younger stages on branch/exception), async reset
//  and a live occupancy count. Sits between decode and later pipeline stages.
// PARAMETERS
//  WIDTH       6   payload bits per stage (>=1)
//  DEPTH       1   number of register stages = latency in clk cycles (>=1)
//  FLUSH_VAL   0   WIDTH-bit value loaded into a flushed or reset stage's data
// PORTS
//  clk         in   1                 pipeline clock; all stages capture on negedge
//  rst_n       in   1                 asynchronous active-low reset
//  in_data     in   WIDTH             payload entering stage 0
//  in_valid    in   1                 in_data carries a live entry
//  stall       in   1                 1 = every stage holds its contents
//  flush_mask  in   DEPTH             bit i = 1 clears stage i this edge
//  out_data    out  WIDTH             stage DEPTH-1 data
//  out_valid   out  1                 stage DEPTH-1 valid
//  stage_valid out  DEPTH             valid bit of every stage, bit i = stage i
//  occupancy   out  $clog2(DEPTH+1)   number of valid stages
// BEHAVIOUR
//  - rst_n low (async, no clock needed): all data = FLUSH_VAL, all valid = 0,
//    occupancy = 0; held until rst_n high; first capture on next negedge clk.
//  - Stage i next state, per negedge clk, in priority order:
//    1. flush_mask[i]=1  -> data=FLUSH_VAL, valid=0
//    2. stall=1          -> hold own data/valid
//    3. otherwise        -> take stage i-1 (stage -1 = in_data/in_valid)
//  - Flush beats stall; stall beats shift. Flushing stage i does not stop stage i's
//    old contents moving to i+1 when stall=0 and flush_mask[i+1]=0.
//  - Invalid entries shift like valid ones; data of an invalid stage is not forced
//    to FLUSH_VAL unless flushed/reset (bubbles keep their payload).
//  - Latency: entry accepted at edge N appears on out_* after edge N+DEPTH-1 with no
//    stall/flush; each stalled edge adds one cycle.
//  - Entry leaving stage DEPTH-1 is dropped; no backpressure, no overflow state.
//  - in_valid/in_data ignored on stalled edges unless flush_mask[0]=1 (then stage 0
//    cleared, input still ignored).
//  - occupancy is registered, updated on the same edge as valid bits, always equal
//    to popcount(stage_valid); range 0..DEPTH, never wraps.
//  - All outputs are direct register outputs; no combinational input->output path.
//  - DEPTH=1, mask=0, stall=0: identical to single-register delay with flush.
//  - rst_n asserted mid-stream: immediate clear regardless of stall/flush/clk.
// TESTING (WIDTH=6, DEPTH=3, FLUSH_VAL=0 unless noted)
//  1. Reset: drive rst_n=0 between edges -> out_data=0, out_valid=0, occupancy=0 at
//     once; after release, feed 0x11,0x22,0x33 valid -> 0x11 on out after 3rd edge,
//     occupancy 1,2,3.
//  2. Stall: fill with 0x0A,0x0B,0x0C; stall=1 for 2 edges with in_data=0x3F ->
//     outputs/occupancy frozen at 0x0A/3; release -> 0x0B,0x0C then 0x3F emerge.
//  3. Selective flush: stages hold 0x01,0x02,0x03 valid; flush_mask=3'b011,
//     stall=0, in_valid=1 0x04 -> stage2=0x02 v, stage1=0 inv, stage0=0 inv,
//     occupancy=1; 0x04 lost.
//  4. Flush+stall: full, stall=1, flush_mask=3'b100 -> stage2 cleared, stages 0,1
//     hold, occupancy 3->2.
//  5. Bubbles: alternate in_valid 1/0 with 0x15 -> stage_valid pattern 101 after 3
//     edges, occupancy 2, bubble payload 0x15 preserved.
//  6. DEPTH=1, FLUSH_VAL=6'h3F: flush_mask=1 -> out_data=0x3F, out_valid=0.

Source files
------------

// File: rtl/pipe_delay_line.sv
// Multi-stage delay line for pipeline payload + valid, with global stall,
// per-stage flush, async reset and a registered occupancy count. Captures on negedge clk.
module pipe_delay_line #(
    parameter int                WIDTH     = 6,
    parameter int                DEPTH     = 1,
    parameter logic [WIDTH-1:0]  FLUSH_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    input  logic                         stall,
    input  logic [DEPTH-1:0]             flush_mask,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    output logic [DEPTH-1:0]             stage_valid,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] data_q   [DEPTH];
    logic [WIDTH-1:0] data_nxt [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_nxt;
    logic [OCC_W-1:0] occ_nxt;

    // Flush is applied last so it overrides both hold and shift.
    always_comb begin
        data_nxt  = data_q;
        valid_nxt = valid_q;
        if (!stall) begin
            data_nxt[0]  = in_data;
            valid_nxt[0] = in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_nxt[i]  = data_q[i-1];
                valid_nxt[i] = valid_q[i-1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (flush_mask[i]) begin
                data_nxt[i]  = FLUSH_VAL;
                valid_nxt[i] = 1'b0;
            end
        end
    end

    always_comb begin
        occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_nxt = occ_nxt + OCC_W'(valid_nxt[i]);
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= FLUSH_VAL;
            end
            valid_q   <= '0;
            occupancy <= '0;
        end else begin
            data_q    <= data_nxt;
            valid_q   <= valid_nxt;
            occupancy <= occ_nxt;
        end
    end

    assign out_data    = data_q[DEPTH-1];
    assign out_valid   = valid_q[DEPTH-1];
    assign stage_valid = valid_q;

endmodule
